// File: rtl/tpsram_rr_arbiter.sv
// tpsram_rr_arbiter: two-requester round-robin arbiter sharing a two-port TPSRAM with per-requester read return
module tpsram_rr_arbiter #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              o_TPSRAM_WEN,
  output logic              o_TPSRAM_REN,
  output logic [ADDR_W-1:0] o_TPSRAM_WADDR_sv,
  output logic [ADDR_W-1:0] o_TPSRAM_RADDR_sv,
  output logic [DATA_W-1:0] o_TPSRAM_WD,
  input  logic [DATA_W-1:0] i_TPSRAM_RD
);
  logic              ptr;
  logic [RD_LAT:0]   vld;
  logic [RD_LAT:0]   own;
  logic              gnt;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  assign gnt0      = !RESET && req0 && (!req1 || !ptr);
  assign gnt1      = !RESET && req1 && (!req0 || ptr);
  assign gnt       = gnt0 || gnt1;
  assign sel_we    = gnt1 ? we1 : we0;
  assign sel_addr  = gnt1 ? addr1 : addr0;
  assign sel_wdata = gnt1 ? wdata1 : wdata0;
  assign rvalid0   = vld[RD_LAT] && !own[RD_LAT];
  assign rvalid1   = vld[RD_LAT] && own[RD_LAT];
  assign rdata0    = rvalid0 ? i_TPSRAM_RD : '0;
  assign rdata1    = rvalid1 ? i_TPSRAM_RD : '0;
  // issue the granted command to the RAM, rotate priority, and track read owners until data returns
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr               <= 1'b0;
      vld               <= '0;
      own               <= '0;
      o_TPSRAM_WEN      <= 1'b0;
      o_TPSRAM_REN      <= 1'b0;
      o_TPSRAM_WADDR_sv <= '0;
      o_TPSRAM_RADDR_sv <= '0;
      o_TPSRAM_WD       <= '0;
    end else begin
      if (gnt) ptr <= gnt0;
      o_TPSRAM_WEN <= gnt && sel_we;
      o_TPSRAM_REN <= gnt && !sel_we;
      if (gnt && sel_we) begin
        o_TPSRAM_WADDR_sv <= sel_addr;
        o_TPSRAM_WD       <= sel_wdata;
      end
      if (gnt && !sel_we) o_TPSRAM_RADDR_sv <= sel_addr;
      vld <= {vld[RD_LAT-1:0], gnt && !sel_we};
      own <= {own[RD_LAT-1:0], gnt1};
    end
  end
endmodule
